// File: rtl/ctr_text_combiner_pkg.sv
// Shared AES/GCM definitions: block and IV widths, counter increment and the
// combiner FSM state encoding.
package ctr_text_combiner_pkg;

    localparam int BLOCK_W = 128;
    localparam int IV_W    = 96;
    localparam int CTR_W   = BLOCK_W - IV_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // GCM inc32: only the low 32-bit word counts, wrapping modulo 2^32.
    function automatic logic [BLOCK_W-1:0] inc32(input logic [BLOCK_W-1:0] blk);
        return {blk[BLOCK_W-1:CTR_W], blk[CTR_W-1:0] + 32'd1};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes when full and pops when
// empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // NOTE: storage is deliberately not reset; count/empty gate every read,
    // and non-blocking writes keep the read of the old head race-free.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ctr_text_combiner.sv
// AES-CTR text combiner: issues a counter block per accepted plaintext block
// and XORs each text block with its in-order keystream for the downstream.
module ctr_text_combiner
    import ctr_text_combiner_pkg::*;
#(
    parameter int                DEPTH       = 16,
    parameter logic [CTR_W-1:0]  CTR_LO_INIT = 32'd2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [IV_W-1:0]    i_iv,
    input  logic               i_text_valid,
    input  logic [BLOCK_W-1:0] i_text,
    input  logic               i_text_last,
    output logic               o_text_ready,
    output logic               o_ctr_valid,
    output logic [BLOCK_W-1:0] o_ctr_block,
    input  logic               i_ks_valid,
    input  logic [BLOCK_W-1:0] i_ks,
    output logic               o_valid,
    output logic [BLOCK_W-1:0] o_data,
    output logic               o_last,
    input  logic               i_ready,
    output logic               o_done,
    output logic               o_err
);
    localparam int CW = $clog2(DEPTH + 1);

    state_t             state, state_nxt;
    logic [BLOCK_W-1:0] counter;
    logic               err_q;
    logic               accept, handoff, ks_drop;
    logic [BLOCK_W:0]   text_head;
    logic [BLOCK_W-1:0] ks_head;
    logic               text_full, text_empty, ks_full, ks_empty;
    logic [CW-1:0]      outstanding, ks_count;

    // Each accepted block waits in the text FIFO until handoff, so that
    // FIFO's occupancy is the outstanding count.
    sync_fifo #(.WIDTH(BLOCK_W + 1), .DEPTH(DEPTH)) u_text_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   ({i_text, i_text_last}),
        .pop   (handoff),
        .dout  (text_head),
        .full  (text_full),
        .empty (text_empty),
        .count (outstanding)
    );

    sync_fifo #(.WIDTH(BLOCK_W), .DEPTH(DEPTH)) u_ks_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (i_ks_valid && !ks_drop),
        .din   (i_ks),
        .pop   (handoff),
        .dout  (ks_head),
        .full  (ks_full),
        .empty (ks_empty),
        .count (ks_count)
    );

    assign accept  = i_text_valid && o_text_ready;
    assign handoff = o_valid && i_ready;
    // Keystream with no block waiting for it is unrequested and dropped.
    assign ks_drop = i_ks_valid && (ks_full || ks_count == outstanding);

    assign o_ctr_valid = accept;
    assign o_ctr_block = counter;
    assign o_valid     = !rst && !text_empty && !ks_empty;
    assign o_data      = text_head[BLOCK_W:1] ^ ks_head;
    assign o_last      = o_valid && text_head[0];
    assign o_err       = !rst && err_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block is defaulted first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_nxt    = state;
        o_text_ready = 1'b0;
        o_done       = 1'b0;
        case (state)
            IDLE: if (i_start) state_nxt = RUN;
            RUN: begin
                o_text_ready = !rst && !text_full;
                if (i_text_valid && o_text_ready && i_text_last) state_nxt = DRAIN;
            end
            DRAIN: if (outstanding == '0) begin
                o_done    = !rst;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)                        counter <= '0;
        else if (state == IDLE && i_start) counter <= {i_iv, CTR_LO_INIT};
        else if (accept)                counter <= inc32(counter);
    end

    always_ff @(posedge clk) begin
        if (rst)          err_q <= 1'b0;
        else if (ks_drop) err_q <= 1'b1;
    end

endmodule

// File: tb/tb_ctr_text_combiner.sv
// Self-checking bench for ctr_text_combiner: a 14-cycle AES model feeds
// keystream back, and a scoreboard checks every downstream handoff.
module tb_ctr_text_combiner;

    localparam int LAT = 14;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
    } exp_t;

    typedef struct {
        logic [127:0] text;
        logic         last;
        logic [31:0]  exp_ctr_lo;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_start;
    logic [95:0]  i_iv;
    logic         i_text_valid;
    logic [127:0] i_text;
    logic         i_text_last;
    logic         o_text_ready;
    logic         o_ctr_valid;
    logic [127:0] o_ctr_block;
    logic         i_ks_valid;
    logic [127:0] i_ks;
    logic         o_valid;
    logic [127:0] o_data;
    logic         o_last;
    logic         i_ready;
    logic         o_done;
    logic         o_err;
    logic         ks_inject;

    // Second instance with the counter low word preset for the wrap test.
    logic         start2, text_valid2, text_ready2, ctr_valid2;
    logic [95:0]  iv2;
    logic [127:0] text2, ctr_block2, data2;
    logic         valid2, last2, done2, err2;

    logic [LAT-1:0] pv = '0;
    logic [127:0]   pd [LAT];
    logic [5:0]     outs;

    exp_t sb[$];
    vec_t vec[3];
    logic [127:0] exp_ctr = '0;
    int n_checks = 0, n_pass = 0;
    int n_accept = 0, n_handoff = 0;
    int cyc = 0, last_ho_cyc = -10;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ctr_text_combiner #(.DEPTH(16)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_iv(i_iv),
        .i_text_valid(i_text_valid), .i_text(i_text), .i_text_last(i_text_last),
        .o_text_ready(o_text_ready), .o_ctr_valid(o_ctr_valid), .o_ctr_block(o_ctr_block),
        .i_ks_valid(i_ks_valid), .i_ks(i_ks), .o_valid(o_valid), .o_data(o_data),
        .o_last(o_last), .i_ready(i_ready), .o_done(o_done), .o_err(o_err)
    );

    ctr_text_combiner #(.DEPTH(16), .CTR_LO_INIT(32'hFFFF_FFFF)) dut2 (
        .clk(clk), .rst(rst), .i_start(start2), .i_iv(iv2),
        .i_text_valid(text_valid2), .i_text(text2), .i_text_last(1'b0),
        .o_text_ready(text_ready2), .o_ctr_valid(ctr_valid2), .o_ctr_block(ctr_block2),
        .i_ks_valid(1'b0), .i_ks(128'h0), .o_valid(valid2), .o_data(data2),
        .o_last(last2), .i_ready(1'b0), .o_done(done2), .o_err(err2)
    );

    function automatic logic [127:0] ks_of(input logic [127:0] ctr);
        return {ctr[63:0], ctr[127:64]} ^ 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0
               ^ {4{ctr[31:0] * 32'h9E37_79B9}};
    endfunction

    // AES pipeline model: fixed latency, not reset, cannot stall.
    always @(posedge clk) begin
        pv    <= {pv[LAT-2:0], o_ctr_valid};
        pd[0] <= ks_of(o_ctr_block);
        for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end
    assign i_ks_valid = pv[LAT-1] | ks_inject;
    assign i_ks       = pv[LAT-1] ? pd[LAT-1] : 128'h0;
    assign outs       = {o_text_ready, o_ctr_valid, o_valid, o_last, o_done, o_err};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard: push on text accept, pop and compare on handoff.
    always @(negedge clk) begin
        exp_t e;
        logic acc;
        if (rst) begin
            sb.delete();
        end else begin
            if (i_start) exp_ctr = {i_iv, 32'd2};
            acc = i_text_valid && o_text_ready;
            if (acc || o_ctr_valid) check("ctr_valid", o_ctr_valid, acc);
            if (acc) begin
                n_accept++;
                check("ctr_block", o_ctr_block, exp_ctr);
                sb.push_back('{data: i_text ^ ks_of(exp_ctr), last: i_text_last});
                exp_ctr = {exp_ctr[127:32], exp_ctr[31:0] + 32'd1};
            end
            if (o_valid && i_ready) begin
                n_handoff++;
                check("handoff_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("o_data", o_data, e.data);
                    check("o_last", o_last, e.last);
                    if (e.last) last_ho_cyc = cyc;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic stream_cycle(output bit acc);
        @(negedge clk);
        acc = i_text_valid && o_text_ready;
        @(posedge clk);
        #1;
        if (acc) i_text = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic send(input logic [127:0] text, input logic last,
                        output logic [127:0] ctr_seen, output bit ok);
        i_text_valid = 1'b1;
        i_text       = text;
        i_text_last  = last;
        ok           = 1'b0;
        ctr_seen     = '0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (o_text_ready) begin
                ok       = 1'b1;
                ctr_seen = o_ctr_block;
            end
            @(posedge clk);
            #1;
        end
        i_text_valid = 1'b0;
        i_text_last  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (o_done) begin
                seen = 1'b1;
                check("done_after_last_handoff", 128'(cyc), 128'(last_ho_cyc + 1));
            end
        end
        check("done_seen", seen, 1);
        @(negedge clk);
        check("done_one_cycle", o_done, 0);
        check("idle_not_ready", o_text_ready, 0);
        check("sb_drained", sb.size(), 0);
        step();
    endtask

    task automatic run_table(input logic [95:0] iv);
        logic [127:0] ctr;
        bit ok;
        i_iv    = iv;
        i_ready = 1'b1;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(vec[i].text, vec[i].last, ctr, ok);
            check("table_accept", ok, 1);
            check("table_ctr", ctr, {iv, vec[i].exp_ctr_lo});
        end
        wait_done(100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ctr_seen [2];
        bit acc;
        int nacc, h0, got;

        vec[0] = '{128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0, 32'h0000_0002};
        vec[1] = '{128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98, 1'b0, 32'h0000_0003};
        vec[2] = '{128'h5A5A5A5A_A5A5A5A5_0F0F0F0F_F0F0F0F0, 1'b1, 32'h0000_0004};

        rst = 1'b1; i_start = 1'b0; i_iv = '0; i_text_valid = 1'b0; i_text = '0;
        i_text_last = 1'b0; i_ready = 1'b0; ks_inject = 1'b0;
        start2 = 1'b0; iv2 = '0; text_valid2 = 1'b0; text2 = '0;
        repeat (3) step();
        @(negedge clk);
        check("reset_outputs", outs, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_outputs", outs, 0);
        step();

        // Three-block message from a zero IV.
        run_table(96'h0);
        check("no_err_basic", o_err, 0);

        // Backpressure: downstream stalled, text offered every cycle.
        i_ready = 1'b0;
        i_iv    = 96'hFEED_0000_1111_2222_3333_4444;
        i_start = 1'b1;
        step();
        i_start      = 1'b0;
        i_text_valid = 1'b1;
        i_text       = {$urandom, $urandom, $urandom, $urandom};
        nacc = 0;
        for (int i = 0; i < 40; i++) begin
            stream_cycle(acc);
            nacc += int'(acc);
        end
        check("backpressure_accepts", nacc, 16);
        @(negedge clk);
        check("full_not_ready", o_text_ready, 0);
        check("full_valid", o_valid, 1);
        check("full_no_err", o_err, 0);
        step();

        // Handoff at outstanding=16 must not open the text port that cycle.
        i_ready = 1'b1;
        @(negedge clk);
        check("full_handoff_not_ready", o_text_ready, 0);
        step();
        i_ready = 1'b0;
        @(negedge clk);
        check("after_handoff_ready", o_text_ready, 1);
        @(posedge clk);
        #1;
        i_text = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        check("refilled_not_ready", o_text_ready, 0);
        step();
        i_ready = 1'b1;
        h0 = n_handoff;
        for (int i = 0; i < 12; i++) stream_cycle(acc);
        check("resume_rate", n_handoff - h0, 12);
        i_text_last = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) stream_cycle(acc);
        check("last_accept", acc, 1);
        i_text_valid = 1'b0;
        i_text_last  = 1'b0;
        wait_done(200);

        // Reset with five blocks in flight.
        i_ready = 1'b0;
        i_iv    = 96'h0BAD_F00D_0000_0000_1234_5678;
        i_start = 1'b1;
        step();
        i_start      = 1'b0;
        i_text_valid = 1'b1;
        nacc = 0;
        for (int i = 0; i < 20 && nacc < 5; i++) begin
            stream_cycle(acc);
            nacc += int'(acc);
        end
        i_text_valid = 1'b0;
        check("mid_accepts", nacc, 5);
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset_outputs", outs, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mid_post_reset_outputs", outs, 0);
        repeat (20) step();
        @(negedge clk);
        check("stale_ks_err", o_err, 1);
        check("stale_ks_no_valid", o_valid, 0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("err_cleared", o_err, 0);
        step();
        run_table(96'h01234567_89ABCDEF_01234567);
        check("no_err_restart", o_err, 0);

        // Keystream with nothing requested, while idle.
        @(negedge clk);
        check("idle_err_before", o_err, 0);
        step();
        ks_inject = 1'b1;
        step();
        ks_inject = 1'b0;
        @(negedge clk);
        check("idle_ks_err", o_err, 1);
        check("idle_ks_no_valid", o_valid, 0);
        repeat (3) step();
        @(negedge clk);
        check("idle_ks_still_no_valid", o_valid, 0);
        check("idle_err_sticky", o_err, 1);
        step();

        // Counter low word wrap on the preset instance.
        iv2    = 96'hCAFE_BABE_0102_0304_0506_0708;
        start2 = 1'b1;
        step();
        start2      = 1'b0;
        text_valid2 = 1'b1;
        text2       = 128'h1;
        got = 0;
        ctr_seen[0] = '0;
        ctr_seen[1] = '0;
        for (int i = 0; i < 10 && got < 2; i++) begin
            @(negedge clk);
            if (ctr_valid2) begin
                ctr_seen[got] = ctr_block2;
                got++;
            end
            step();
        end
        text_valid2 = 1'b0;
        check("wrap_accepts", got, 2);
        check("wrap_ctr_ffffffff", ctr_seen[0], {iv2, 32'hFFFF_FFFF});
        check("wrap_ctr_00000000", ctr_seen[1], {iv2, 32'h0000_0000});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
